aer_in: RTL and testbench

- Receiving end of the team's 4-phase AER link; mirrors the transmitter that drives AEROUT_ADDR/REQ and samples AEROUT_ACK.
- Synchronises the asynchronous incoming REQ and latches the address when REQ is seen.
- Acknowledges with a full 4-phase handshake and buffers received addresses in a small FIFO.
- Downstream logic (pixel/sorter side) consumes the FIFO over a valid/ready interface.

---
 rtl/aer_pkg.sv | 22 ++
 rtl/aer_in_fifo.sv | 70 +++++++
 rtl/aer_in.sv | 91 +++++++++
 tb/tb_aer_in.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/aer_pkg.sv
// aer_pkg: shared types and width helpers for the AER link endpoints (aer_in / aer_out).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package aer_pkg;

   // Receiver handshake states: waiting for a request, or holding ACK high.
   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      ACK_HI = 1'b1
   } aer_rx_state_t;

   // Default array size shared by both link ends.
   localparam int AER_IMAGE_SIZE_DEFAULT = 5;

   // The address bus carries $clog2(image_size)+1 bits (MSB index = $clog2(image_size)).
   function automatic int aer_addr_width(input int image_size);
      return $clog2(image_size) + 1;
   endfunction

   localparam int AER_ADDR_W_DEFAULT = aer_addr_width(AER_IMAGE_SIZE_DEFAULT);

endpackage

// File: rtl/aer_in_fifo.sv
// aer_in_fifo: circular event buffer with show-ahead head, registered count, VALID and FULL.
// Latency: a push is visible at the head one edge later if the buffer was empty.
// Backpressure: FULL is reported to the writer; pushes while full and pops while empty are ignored.
module aer_in_fifo
   import aer_pkg::*;
#(
   parameter int DEPTH    = 4,
   parameter int PTR_BITS = $clog2(DEPTH),
   parameter int WIDTH    = AER_ADDR_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_addr,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             valid,
   output logic             full
);

   // DEPTH must be a power of two so the pointers wrap by plain overflow.
   logic [WIDTH-1:0]  mem [DEPTH];
   logic [PTR_BITS-1:0] wr_ptr;
   logic [PTR_BITS-1:0] rd_ptr;
   logic [PTR_BITS:0]   count;
   logic                do_push;
   logic                do_pop;

   // Flags come straight from the registered count.
   assign valid = (count != '0);
   assign full  = (count == (PTR_BITS + 1)'(DEPTH));
   assign head  = mem[rd_ptr];

   // Qualify requests: never overwrite a full buffer, never pop an empty one.
   assign do_push = push && !full;
   assign do_pop  = pop && valid;

   // Storage write; cleared on reset so the head reads zero after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (do_push) begin
         mem[wr_ptr] <= push_addr;
      end
   end

   // Pointer and occupancy update; simultaneous push and pop leave count unchanged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_BITS'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_BITS'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + (PTR_BITS + 1)'(1);
            2'b01:   count <= count - (PTR_BITS + 1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/aer_in.sv
// aer_in: 4-phase AER receiver; synchronises REQ, acknowledges, and queues addresses for a valid/ready consumer.
// Latency: REQ rise -> ACK high and event visible after 3 edges; REQ fall -> ACK low after 3 edges.
// Backpressure: when the event buffer is full the request is left unacknowledged until space frees up.
module aer_in
   import aer_pkg::*;
#(
   parameter int IMAGE_SIZE      = AER_IMAGE_SIZE_DEFAULT,
   parameter int IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE),
   parameter int FIFO_DEPTH      = 4,
   parameter int FIFO_PTR_BITS   = $clog2(FIFO_DEPTH)
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic [IMAGE_SIZE_BITS:0] AERIN_ADDR,
   input  logic                     AERIN_REQ,
   output logic                     AERIN_ACK,
   output logic [IMAGE_SIZE_BITS:0] EVT_ADDR,
   output logic                     EVT_VALID,
   input  logic                     EVT_READY,
   output logic                     FIFO_FULL,
   output logic                     RX_BUSY
);

   logic          req_sync_int;
   logic          req_sync;
   aer_rx_state_t state;
   logic          push;
   logic          pop;

   // Two-flop barrier on the asynchronous request; only req_sync is used below.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         req_sync_int <= 1'b0;
         req_sync     <= 1'b0;
      end else begin
         req_sync_int <= AERIN_REQ;
         req_sync     <= req_sync_int;
      end
   end

   // Accept only from IDLE with space available. The address is not synchronised:
   // the transmitter holds it stable from before REQ rises until it sees ACK.
   // FIFO_FULL is this cycle's value, so a same-cycle pop delays the push by one edge.
   assign push = (state == IDLE) && req_sync && !FIFO_FULL;
   assign pop  = EVT_VALID && EVT_READY;

   // Handshake FSM with registered ACK: raise with the push, drop once REQ is seen low.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= IDLE;
         AERIN_ACK <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_sync && !FIFO_FULL) begin
                  AERIN_ACK <= 1'b1;
                  state     <= ACK_HI;
               end
            end
            ACK_HI: begin
               if (!req_sync) begin
                  AERIN_ACK <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               AERIN_ACK <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

   assign RX_BUSY = (state != IDLE);

   aer_in_fifo #(
      .DEPTH    (FIFO_DEPTH),
      .PTR_BITS (FIFO_PTR_BITS),
      .WIDTH    (IMAGE_SIZE_BITS + 1)
   ) u_fifo (
      .clk       (CLK),
      .rst       (RST),
      .push      (push),
      .push_addr (AERIN_ADDR),
      .pop       (pop),
      .head      (EVT_ADDR),
      .valid     (EVT_VALID),
      .full      (FIFO_FULL)
   );

endmodule

// File: tb/tb_aer_in.sv
// tb_aer_in: randomized and directed stimulus of a 4-phase transmitter, with a scoreboard
// of issued addresses checked in order by an independent consumer-side monitor,
// plus a watcher on the ACK/req_sync handshake relation.
module tb_aer_in;

   localparam int AW = 4;

   logic          CLK;
   logic          RST;
   logic [AW-1:0] AERIN_ADDR;
   logic          AERIN_REQ;
   logic          AERIN_ACK;
   logic [AW-1:0] EVT_ADDR;
   logic          EVT_VALID;
   logic          EVT_READY;
   logic          FIFO_FULL;
   logic          RX_BUSY;

   int n_checks = 0;
   int n_fail   = 0;

   // Expected consumer-side order: every issued event, in issue order, no drops.
   logic [AW-1:0] exp_q[$];
   logic          rnd_on;

   aer_in #(
      .IMAGE_SIZE (5),
      .FIFO_DEPTH (4)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .AERIN_ADDR (AERIN_ADDR),
      .AERIN_REQ  (AERIN_REQ),
      .AERIN_ACK  (AERIN_ACK),
      .EVT_ADDR   (EVT_ADDR),
      .EVT_VALID  (EVT_VALID),
      .EVT_READY  (EVT_READY),
      .FIFO_FULL  (FIFO_FULL),
      .RX_BUSY    (RX_BUSY)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic tick();
      @(posedge CLK);
      #2;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic wait_ack(input logic val, input int budget, input string name);
      for (int i = 0; i < budget && AERIN_ACK !== val; i++) tick();
      check(name, AERIN_ACK, val);
   endtask

   // Full 4-phase transaction from the transmitter side.
   task automatic send(input logic [AW-1:0] a, input int budget);
      AERIN_ADDR = a;
      exp_q.push_back(a);
      AERIN_REQ = 1'b1;
      wait_ack(1'b1, budget, "ack_rise");
      AERIN_REQ = 1'b0;
      wait_ack(1'b0, budget, "ack_fall");
   endtask

   task automatic drain(input int budget);
      EVT_READY = 1'b1;
      for (int i = 0; i < budget && EVT_VALID; i++) tick();
      EVT_READY = 1'b0;
      tick();
      check("drain_empty", EVT_VALID, 1'b0);
      check("drain_scoreboard_left", exp_q.size(), 0);
   endtask

   // Consumer monitor: every accepted pop must match the next expected address.
   initial begin
      logic [AW-1:0] e;
      forever begin
         @(negedge CLK);
         if (!RST && EVT_VALID && EVT_READY) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_event: got %0d, expected nothing at %0t", EVT_ADDR, $time);
            end else begin
               e = exp_q.pop_front();
               check("evt_addr", EVT_ADDR, e);
            end
         end
      end
   end

   // Handshake watcher: ACK may only rise with req_sync high and only fall with req_sync low.
   logic p_ack, p_sync, p_rst;
   initial begin
      p_ack = 1'b0; p_sync = 1'b0; p_rst = 1'b1;
      forever begin
         @(negedge CLK);
         if (!RST && !p_rst) begin
            if (AERIN_ACK && !p_ack) check("ack_rise_needs_req_sync", p_sync, 1'b1);
            if (!AERIN_ACK && p_ack) check("ack_fall_needs_no_req_sync", p_sync, 1'b0);
         end
         p_ack  = AERIN_ACK;
         p_sync = dut.req_sync;
         p_rst  = RST;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      RST = 1'b1; AERIN_REQ = 1'b0; AERIN_ADDR = '0; EVT_READY = 1'b0; rnd_on = 1'b0;
      repeat (2) @(posedge CLK);
      #2;
      check("rst_ack", AERIN_ACK, 0);
      check("rst_valid", EVT_VALID, 0);
      check("rst_full", FIFO_FULL, 0);
      check("rst_busy", RX_BUSY, 0);
      check("rst_addr", EVT_ADDR, 0);
      RST = 1'b0;
      tick();

      // Single event with exact latency.
      AERIN_ADDR = 4'd3; exp_q.push_back(4'd3); AERIN_REQ = 1'b1;
      tick(); tick();
      check("lat_ack_edge2", AERIN_ACK, 0);
      tick();
      check("lat_ack_edge3", AERIN_ACK, 1);
      check("lat_valid_edge3", EVT_VALID, 1);
      check("lat_addr_edge3", EVT_ADDR, 3);
      AERIN_REQ = 1'b0;
      tick(); tick();
      check("fall_ack_edge2", AERIN_ACK, 1);
      tick();
      check("fall_ack_edge3", AERIN_ACK, 0);
      check("fall_busy", RX_BUSY, 0);
      drain(20);

      // Fill to capacity, then back-pressure on the fifth request.
      for (int i = 1; i <= 4; i++) send(AW'(i), 20);
      check("full_after_4", FIFO_FULL, 1);
      AERIN_ADDR = 4'd5; exp_q.push_back(4'd5); AERIN_REQ = 1'b1;
      repeat (8) tick();
      check("bp_no_ack", AERIN_ACK, 0);
      check("bp_not_busy", RX_BUSY, 0);
      check("bp_still_full", FIFO_FULL, 1);
      EVT_READY = 1'b1;
      tick();
      EVT_READY = 1'b0;
      wait_ack(1'b1, 2, "bp_ack_after_pop");
      AERIN_REQ = 1'b0;
      wait_ack(1'b0, 10, "bp_ack_fall");
      drain(20);

      // Wrap-around with the consumer always ready.
      EVT_READY = 1'b1;
      for (int i = 0; i < 10; i++) send(AW'(i), 20);
      drain(20);

      // Randomized addresses against a randomly stalling consumer.
      rnd_on = 1'b1;
      fork
         begin
            for (int i = 0; i < 40; i++) begin
               send(AW'($urandom_range(0, 15)), 200);
               repeat ($urandom_range(0, 3)) tick();
            end
            rnd_on = 1'b0;
         end
         begin
            while (rnd_on) begin
               @(posedge CLK);
               #1;
               EVT_READY = 1'($urandom_range(0, 1));
            end
         end
      join
      drain(40);

      // Push and pop on the same edge.
      send(4'd7, 20);
      AERIN_ADDR = 4'd8; exp_q.push_back(4'd8); AERIN_REQ = 1'b1;
      tick(); tick();
      EVT_READY = 1'b1;
      tick();
      EVT_READY = 1'b0;
      check("pp_ack", AERIN_ACK, 1);
      check("pp_count", dut.u_fifo.count, 1);
      check("pp_head", EVT_ADDR, 8);
      AERIN_REQ = 1'b0;
      wait_ack(1'b0, 10, "pp_ack_fall");
      drain(20);

      // Reset in the middle of a handshake with two entries queued.
      send(4'd10, 20);
      AERIN_ADDR = 4'd11; AERIN_REQ = 1'b1;
      wait_ack(1'b1, 10, "mid_ack");
      check("mid_count", dut.u_fifo.count, 2);
      RST = 1'b1;
      #1;
      check("mid_rst_ack", AERIN_ACK, 0);
      check("mid_rst_valid", EVT_VALID, 0);
      check("mid_rst_busy", RX_BUSY, 0);
      check("mid_rst_addr", EVT_ADDR, 0);
      exp_q.delete();
      exp_q.push_back(4'd11);
      tick();
      RST = 1'b0;
      wait_ack(1'b1, 10, "reacc_ack");
      AERIN_REQ = 1'b0;
      wait_ack(1'b0, 10, "reacc_ack_fall");
      repeat (4) tick();
      check("reacc_count", dut.u_fifo.count, 1);
      check("reacc_head", EVT_ADDR, 11);
      drain(20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
